dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
Shares the dual-port data memory (ports A and B) between the main core and the subcores.
- Each requester presents one word request per cycle on a valid/ready handshake.
- Up to two requests are granted per cycle, one per memory port.
- Read data is routed back to the owning requester with fixed latency.
- Sits between the core memory stages and the data memory array; replaces direct per-lane wiring of memory ports.

Parameters:
NUM_REQ, 5, requester count; index 0 = main core, 1..NUM_REQ-1 = subcores (SUBCORE_NUM+1)
ADDR_W, 17, word address width
DATA_W, 32, data width

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  synchronous active-high reset
hold  in  1  pipeline interlock; when high no new grants
req_valid  in  NUM_REQ  request present, per requester
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  word address, packed, requester i at [i*ADDR_W +: ADDR_W]
req_din  in  NUM_REQ*DATA_W  write data, packed
req_ready  out  NUM_REQ  request accepted this cycle (combinational)
resp_valid  out  NUM_REQ  read data valid for requester i
resp_data  out  NUM_REQ*DATA_W  read data, packed
mem_addra/mem_addrb  out  ADDR_W  memory port address
mem_dina/mem_dinb  out  DATA_W  memory write data
mem_wea/mem_web  out  1  memory write enable
mem_douta/mem_doutb  in  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Reset: req_ready=0, resp_valid=0, resp_data=0, mem_* outputs=0, rr_ptr=1, tag pipeline cleared.
- Accept:
  - accept_i = req_valid[i] & req_ready[i] in cycle t.
  - req_ready is combinational from req_valid, hold, rr_ptr and conflict check.
  - Requesters must keep addr/we/din stable while valid and not ready.
- Selection, each cycle with hold=0:
  - Requester 0 valid -> takes port A.
  - Remaining ports are filled round-robin over 1..NUM_REQ-1, starting at rr_ptr, wrapping NUM_REQ-1 -> 1.
  - First RR pick takes port A if free, else port B; second RR pick takes port B.
- Conflict rule:
  - If the two picks have equal addresses and at least one writes, only the port-A pick is granted.
  - The losing requester keeps ready=0 and retries next cycle.
  - Two reads to the same address are both granted.
- rr_ptr update: after any RR grant, advances to last granted RR index +1, wrapping to 1; otherwise unchanged.
- hold=1: req_ready=0 for all; mem_wea/web forced 0; the tag pipeline still advances, so in-flight responses drain.
- Cycle t+1: mem_addr*/din*/we* are registered from the grant of cycle t. Ports with no grant drive we=0, and addr/din hold their last value.
- Cycle t+2: mem_dout* is captured. For a read grant, resp_valid[i]=1 for exactly one cycle and resp_data[i] = captured word.
- Writes generate no response.
- Tag pipeline: 2 stages × 2 ports of {valid, is_read, requester_index}.
- Throughput: full, 2 accesses/cycle sustained; latency 2 cycles from accept to resp_valid.
- Reset mid-operation: all in-flight tags are dropped; no resp_valid after reset; no memory write in the cycle following reset.
- Out-of-range index never reachable; ADDR_W addresses pass unmodified (no byte shift).

Decomposition:
- Shared package: NUM_REQ default tied to SUBCORE_NUM+1, ADDR_W, DATA_W, and a typedef port_tag_t {valid, is_read, idx}.
- One sub-module, rr_pick2: combinational, returns the first two set bits of a mask starting at a pointer with wrap. Reused for the A/B selection.

Test Plan:
1. Reset, then req 0 read addr 0x10 (memory preloaded 0x10=0xDEADBEEF) -> req_ready[0]=1 at t, mem_addra=0x10 at t+1, resp_valid[0]=1 and resp_data[0]=0xDEADBEEF at t+2, single cycle.
2. Requesters 1..4 all reading each cycle, req 0 idle, rr_ptr=1 -> grants (1,2), (3,4), (1,2) on successive cycles; each resp returns 2 cycles after its grant.
3. Req 0 writes 0x20=0x55, req 1 reads 0x20 same cycle -> only req 0 ready; req 1 granted next cycle and reads 0x55.
4. Req 1 and req 2 both read 0x30 -> both ready same cycle, both receive identical data at t+2.
5. Requesters 0,1,2 valid with hold=1 for 3 cycles -> all req_ready=0, mem_we*=0; responses accepted just before hold still appear on schedule; grants resume the cycle hold falls.
6. Grant reads at t, assert rst at t+1 -> no resp_valid at t+2 or after, all outputs at reset values, rr_ptr=1.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: shared sizes and per-port tag type for the data memory arbiter
package dmem_port_arbiter_pkg;
  localparam int SUBCORE_NUM = 4;
  localparam int NUM_REQ = SUBCORE_NUM + 1;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef struct packed {
    logic valid;
    logic is_read;
    logic [IDX_W-1:0] idx;
  } port_tag_t;
endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// rr_pick2: first two set bits of mask, scanning upward from ptr with wrap
module rr_pick2 #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic         first_vld,
  output logic [W-1:0] first_idx,
  output logic         second_vld,
  output logic [W-1:0] second_idx
);
  always_comb begin
    int j;
    j = 0;
    first_vld = 1'b0;
    first_idx = '0;
    second_vld = 1'b0;
    second_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (mask[j] && first_vld && !second_vld) begin
        second_vld = 1'b1;
        second_idx = W'(j);
      end
      if (mask[j] && !first_vld) begin
        first_vld = 1'b1;
        first_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares dual-port data memory between main core and subcores, 2 grants/cycle
module dmem_port_arbiter #(
  parameter int NUM_REQ = dmem_port_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = dmem_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = dmem_port_arbiter_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_din,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ*DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0]         mem_addra,
  output logic [ADDR_W-1:0]         mem_addrb,
  output logic [DATA_W-1:0]         mem_dina,
  output logic [DATA_W-1:0]         mem_dinb,
  output logic                      mem_wea,
  output logic                      mem_web,
  input  logic [DATA_W-1:0]         mem_douta,
  input  logic [DATA_W-1:0]         mem_doutb
);
  import dmem_port_arbiter_pkg::*;
  localparam int RW = $clog2(NUM_REQ - 1);
  logic [IDX_W-1:0] rr_ptr, rr_nxt, a_idx, b_idx, last;
  logic [RW-1:0] rr_base, f_idx, s_idx;
  logic f_v, s_v, a_v, b_v, ga, gb, clash, a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_din, b_din;
  port_tag_t [1:0] tag1, tag2;
  assign rr_base = RW'(rr_ptr - 1'b1);
  rr_pick2 #(.N(NUM_REQ - 1)) u_pick (
    .mask(req_valid[NUM_REQ-1:1]),
    .ptr(rr_base),
    .first_vld(f_v),
    .first_idx(f_idx),
    .second_vld(s_v),
    .second_idx(s_idx)
  );
  assign a_addr = req_addr[a_idx*ADDR_W +: ADDR_W];
  assign b_addr = req_addr[b_idx*ADDR_W +: ADDR_W];
  assign a_din = req_din[a_idx*DATA_W +: DATA_W];
  assign b_din = req_din[b_idx*DATA_W +: DATA_W];
  assign a_we = req_we[a_idx];
  assign b_we = req_we[b_idx];
  // main core owns port A when present; RR picks fill whatever remains
  always_comb begin
    a_v = req_valid[0] | f_v;
    a_idx = req_valid[0] ? '0 : IDX_W'(f_idx) + 1'b1;
    b_v = req_valid[0] ? f_v : s_v;
    b_idx = IDX_W'(req_valid[0] ? f_idx : s_idx) + 1'b1;
    clash = a_v && b_v && (a_addr == b_addr) && (a_we || b_we);
    ga = a_v && !hold && !rst;
    gb = b_v && !hold && !rst && !clash;
    req_ready = (ga ? NUM_REQ'(1) << a_idx : '0) | (gb ? NUM_REQ'(1) << b_idx : '0);
    last = gb ? b_idx : a_idx;
    rr_nxt = (gb || (ga && !req_valid[0])) ?
             ((last == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : last + 1'b1) : rr_ptr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= IDX_W'(1);
      mem_addra <= '0;
      mem_addrb <= '0;
      mem_dina <= '0;
      mem_dinb <= '0;
      mem_wea <= 1'b0;
      mem_web <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      mem_wea <= ga && a_we;
      mem_web <= gb && b_we;
      mem_addra <= ga ? a_addr : mem_addra;
      mem_dina <= ga ? a_din : mem_dina;
      mem_addrb <= gb ? b_addr : mem_addrb;
      mem_dinb <= gb ? b_din : mem_dinb;
      tag1[0] <= port_tag_t'{ga, ga && !a_we, a_idx};
      tag1[1] <= port_tag_t'{gb, gb && !b_we, b_idx};
      tag2 <= tag1;
    end
  end
  // memory output of the second tag stage belongs to that tag's requester
  always_comb begin
    resp_valid = '0;
    resp_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (tag2[p].valid && tag2[p].is_read && !rst) begin
        resp_valid[tag2[p].idx] = 1'b1;
        resp_data[tag2[p].idx*DATA_W +: DATA_W] = (p == 1) ? mem_doutb : mem_douta;
      end
    end
  end
endmodule
